// File: rtl/adbg_sync_pkg.sv
// adbg_sync_pkg: shared mode encodings and parameter limits for the debug CDC bus register
package adbg_sync_pkg;
  localparam int MODE_LEVEL      = 0;
  localparam int MODE_PUSH       = 1;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int WIDTH_MAX       = 64;

  function automatic bit params_ok(input int width, input int stages, input int mode);
    return width >= 1 && width <= WIDTH_MAX &&
           stages >= SYNC_STAGES_MIN && stages <= SYNC_STAGES_MAX &&
           (mode == MODE_LEVEL || mode == MODE_PUSH);
  endfunction
endpackage

// File: rtl/adbg_sync_toggle.sv
// adbg_sync_toggle: N-stage 1-bit toggle synchroniser with an edge pulse taken from flopped bits
module adbg_sync_toggle #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_edge
);
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;
  logic r_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_d    <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_d    <= r_sync[STAGES-1];
    end
  end

  // Both operands are flops, so the pulse is glitch-free in the destination domain
  assign o_q    = r_sync[STAGES-1];
  assign o_edge = r_sync[STAGES-1] ^ r_d;
endmodule

// File: rtl/adbg_syncbus.sv
// adbg_syncbus: carries a word from CLKA to CLKB with a two-phase toggle req/ack handshake
// MODE_LEVEL follows DATA_IN automatically; MODE_PUSH transfers on A_VALID & A_READY.
module adbg_syncbus
  import adbg_sync_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               MODE        = MODE_LEVEL,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLKA,
  input  logic             CLKB,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             A_VALID,
  output logic             A_READY,
  output logic             A_BUSY,
  output logic [WIDTH-1:0] B_DATA,
  output logic             B_UPDATE
);
  logic [WIDTH-1:0] r_hold_a;
  logic [WIDTH-1:0] r_b_data;
  logic             r_req_tgl;
  logic             r_ack_tgl;
  logic             r_b_update;
  logic             w_req_s;
  logic             w_req_edge;
  logic             w_ack_s;
  logic             w_unused_ack_edge;
  logic             w_launch;

  if (!params_ok(WIDTH, SYNC_STAGES, MODE)) begin : g_param_check
    $error("adbg_syncbus: illegal WIDTH, SYNC_STAGES or MODE");
  end

  assign A_BUSY   = r_req_tgl ^ w_ack_s;
  assign A_READY  = !A_BUSY;
  assign w_launch = !A_BUSY && (MODE == MODE_PUSH ? A_VALID : DATA_IN != r_hold_a);
  assign B_DATA   = r_b_data;
  assign B_UPDATE = r_b_update;

  // r_hold_a only changes on launch, which needs !A_BUSY, so it is static while B samples it
  always_ff @(posedge CLKA or posedge RST) begin
    if (RST) begin
      r_hold_a  <= RESET_VALUE;
      r_req_tgl <= 1'b0;
    end else if (w_launch) begin
      r_hold_a  <= DATA_IN;
      r_req_tgl <= ~r_req_tgl;
    end
  end

  adbg_sync_toggle #(.STAGES(SYNC_STAGES)) u_req_sync (
    .i_clk  (CLKB),
    .i_rst  (RST),
    .i_d    (r_req_tgl),
    .o_q    (w_req_s),
    .o_edge (w_req_edge)
  );

  always_ff @(posedge CLKB or posedge RST) begin
    if (RST) begin
      r_b_data   <= RESET_VALUE;
      r_ack_tgl  <= 1'b0;
      r_b_update <= 1'b0;
    end else begin
      r_b_update <= w_req_edge;
      if (w_req_edge) begin
        r_b_data  <= r_hold_a;
        r_ack_tgl <= w_req_s;
      end
    end
  end

  adbg_sync_toggle #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .i_clk  (CLKA),
    .i_rst  (RST),
    .i_d    (r_ack_tgl),
    .o_q    (w_ack_s),
    .o_edge (w_unused_ack_edge)
  );
endmodule

// File: tb/tb_adbg_syncbus.sv
// tb_adbg_syncbus: scoreboard bench for a level-follow (8-bit) and a push-mode (16-bit) instance
`timescale 1ns/1ps
module tb_adbg_syncbus;
  logic clka = 1'b0;
  logic clkb = 1'b0;
  logic rst  = 1'b1;
  realtime ha = 5.0;
  realtime hb = 13.5;

  logic [7:0]  d0 = '0;
  logic        v0 = 1'b0;
  logic        rdy0, bsy0, upd0;
  logic [7:0]  bd0;
  logic [15:0] d1 = '0;
  logic        v1 = 1'b0;
  logic        rdy1, bsy1, upd1;
  logic [15:0] bd1;

  int tests = 0;
  int fails = 0;
  int cnt0  = 0;
  int cnt1  = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  adbg_syncbus #(.WIDTH(8), .SYNC_STAGES(2), .MODE(0), .RESET_VALUE(8'h00)) u_lvl (
    .CLKA(clka), .CLKB(clkb), .RST(rst), .DATA_IN(d0), .A_VALID(v0),
    .A_READY(rdy0), .A_BUSY(bsy0), .B_DATA(bd0), .B_UPDATE(upd0)
  );

  adbg_syncbus #(.WIDTH(16), .SYNC_STAGES(2), .MODE(1), .RESET_VALUE(16'h0000)) u_push (
    .CLKA(clka), .CLKB(clkb), .RST(rst), .DATA_IN(d1), .A_VALID(v1),
    .A_READY(rdy1), .A_BUSY(bsy1), .B_DATA(bd1), .B_UPDATE(upd1)
  );

  always #(ha) clka = ~clka;
  initial begin
    #3.3;
    forever #(hb) clkb = ~clkb;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_a(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  // Scoreboard: every B_UPDATE must match the oldest word queued when stimulus was driven
  always @(posedge clkb) begin
    #1;
    if (upd0 === 1'b1) begin
      cnt0++;
      chk("lvl_upd_expected", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) chk("lvl_bdata", 64'(bd0), q0.pop_front());
    end
    if (upd1 === 1'b1) begin
      cnt1++;
      chk("push_upd_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) chk("push_bdata", 64'(bd1), q1.pop_front());
    end
  end

  task automatic push1(input logic [15:0] v, input bit expect_xfer);
    int n;
    n = 0;
    d1 = v;
    v1 = 1'b1;
    while (!rdy1 && n < 200) begin
      tick_a(1);
      n++;
    end
    chk("push_ready", 64'(rdy1), 64'd1);
    if (expect_xfer) q1.push_back(64'(v));
    tick_a(1);
    v1 = 1'b0;
  endtask

  task automatic wait_cnt(input int which, input int target);
    int n;
    n = 0;
    while ((which == 0 ? cnt0 : cnt1) < target && n < 400) begin
      @(posedge clkb);
      #2;
      n++;
    end
    chk(which == 0 ? "lvl_wait_cnt" : "push_wait_cnt", 64'(which == 0 ? cnt0 : cnt1), 64'(target));
  endtask

  task automatic wait_idle(input int which);
    int n;
    n = 0;
    while ((which == 0 ? bsy0 : bsy1) && n < 200) begin
      tick_a(1);
      n++;
    end
    chk(which == 0 ? "lvl_idle" : "push_idle", 64'(which == 0 ? bsy0 : bsy1), 64'd0);
  endtask

  initial begin
    int bs;
    int k;
    tick_a(3);
    chk("rst_busy0", 64'(bsy0), 64'd0);
    chk("rst_ready0", 64'(rdy0), 64'd1);
    chk("rst_bdata0", 64'(bd0), 64'd0);
    chk("rst_upd0", 64'(upd0), 64'd0);
    chk("rst_ready1", 64'(rdy1), 64'd1);
    chk("rst_bdata1", 64'(bd1), 64'd0);
    rst = 1'b0;

    // Level mode idle at the reset value; A_VALID must have no effect
    v0 = 1'b1;
    bs = 0;
    repeat (50) begin
      tick_a(1);
      bs += int'(bsy0);
    end
    v0 = 1'b0;
    chk("idle_busy", 64'(bs), 64'd0);
    chk("idle_upd_cnt", 64'(cnt0), 64'd0);
    chk("idle_bdata", 64'(bd0), 64'd0);

    // Single change 0x00 -> 0xA5: B_DATA within SYNC_STAGES+2 CLKB edges of the launch edge
    q0.push_back(64'h A5);
    d0 = 8'hA5;
    @(posedge clka);
    k = 0;
    do begin
      @(posedge clkb);
      k++;
      #1;
    end while (upd0 !== 1'b1 && k < 20);
    chk("a5_latency_ok", 64'(k <= 4), 64'd1);
    chk("a5_bdata", 64'(bd0), 64'h A5);
    wait_idle(0);
    tick_a(10);
    chk("a5_one_pulse", 64'(cnt0), 64'd1);

    // Coalescing: 0x22 is overwritten while busy and must never reach B
    q0.push_back(64'h11);
    q0.push_back(64'h33);
    d0 = 8'h11;
    tick_a(1);
    d0 = 8'h22;
    tick_a(1);
    d0 = 8'h33;
    wait_cnt(0, 3);
    wait_idle(0);
    tick_a(10);
    chk("coalesce_cnt", 64'(cnt0), 64'd3);
    chk("coalesce_bdata", 64'(bd0), 64'h33);
    chk("coalesce_q_empty", 64'(q0.size()), 64'd0);

    // Push mode, CLKA three times faster than CLKB
    ha = 5.0;
    hb = 15.0;
    tick_a(4);
    for (int i = 0; i < 16; i++) push1(16'(i), 1'b1);
    wait_cnt(1, 16);
    wait_idle(1);
    chk("push31_q_empty", 64'(q1.size()), 64'd0);
    chk("push31_bdata", 64'(bd1), 64'h000F);

    // Push mode, CLKB three times faster than CLKA
    ha = 15.0;
    hb = 5.0;
    tick_a(4);
    for (int i = 0; i < 16; i++) push1(16'(i), 1'b1);
    wait_cnt(1, 32);
    wait_idle(1);
    chk("push13_q_empty", 64'(q1.size()), 64'd0);

    // Equal word pushed twice still produces two updates
    push1(16'h0005, 1'b1);
    push1(16'h0005, 1'b1);
    wait_cnt(1, 34);
    wait_idle(1);
    tick_a(10);
    chk("dup5_cnt", 64'(cnt1), 64'd34);
    chk("dup5_bdata", 64'(bd1), 64'h0005);

    // Reset two CLKB cycles after launching 0xF: the word is discarded
    d0 = 8'h00;
    push1(16'h000F, 1'b0);
    repeat (2) @(posedge clkb);
    #1;
    rst = 1'b1;
    #2;
    chk("midrst_bdata1", 64'(bd1), 64'd0);
    chk("midrst_busy1", 64'(bsy1), 64'd0);
    repeat (3) @(posedge clka);
    #1;
    rst = 1'b0;
    tick_a(1);
    chk("midrst_ready1", 64'(rdy1), 64'd1);
    tick_a(30);
    chk("midrst_no_upd1", 64'(cnt1), 64'd34);
    chk("midrst_no_upd0", 64'(cnt0), 64'd3);
    chk("midrst_bdata1_after", 64'(bd1), 64'd0);
    chk("midrst_bdata0_after", 64'(bd0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adbg_syncbus.md
Name: adbg_syncbus

Overview:
Parametrised clock-domain-crossing register for debug-unit control and status buses. It carries a WIDTH-bit word from the CLKA domain to the CLKB domain using a two-phase toggle request/acknowledge handshake. Two modes are supported:
- MODE 0: automatic level-follow.
- MODE 1: explicit valid/ready push.
Extra outputs: a CLKB-side update strobe and a CLKA-side busy flag. It replaces the fixed 4-bit sync register in the debug WishBone/CPU interface paths.

Parameters:
- WIDTH, 4: data word width in bits, 1..64.
- SYNC_STAGES, 2: synchroniser flops per crossing direction, 2..4.
- MODE, 0: 0 = level-follow (transfer whenever DATA_IN differs from the last sent word); 1 = push (transfer on A_VALID & A_READY).
- RESET_VALUE, '0: WIDTH-bit value of the A-side holding register and B_DATA after reset.

Ports:
- CLKA  in  1  source-domain clock
- CLKB  in  1  destination-domain clock
- RST  in  1  asynchronous active-high reset, both domains
- DATA_IN  in  WIDTH  source word (CLKA domain)
- A_VALID  in  1  push request (MODE 1 only; ignored in MODE 0)
- A_READY  out  1  = !A_BUSY; in MODE 1 a transfer is accepted when A_VALID & A_READY
- A_BUSY  out  1  transfer in flight (request toggle != synchronised ack toggle)
- B_DATA  out  WIDTH  destination word (CLKB domain, registered)
- B_UPDATE  out  1  one-CLKB-cycle pulse, coincident with the cycle B_DATA first shows a new word

Interface: reset RST, asynchronous, active-high; clock CLKA. CLKB is a second, fully asynchronous clock. RST deassertion is synchronised to each clock externally by the integrator.

Behaviour:
- Reset values: hold_a = RESET_VALUE, B_DATA = RESET_VALUE, req_tgl = 0, ack_tgl = 0, all sync flops = 0, A_BUSY = 0, A_READY = 1, B_UPDATE = 0. Because both sides reset to the same value, no start-up transfer is needed.
- A-side launch, on a CLKA edge with !A_BUSY:
  - MODE 0: launch when DATA_IN != hold_a.
  - MODE 1: launch when A_VALID.
  - On launch: hold_a <= DATA_IN, req_tgl <= ~req_tgl, and A_BUSY rises on the next cycle.
- hold_a is stable whenever A_BUSY = 1. This is the CDC guarantee: B samples hold_a only while it is static.
- B-side:
  - req_tgl passes through SYNC_STAGES CLKB flops to give req_s, plus one more flop req_d.
  - edge = req_s ^ req_d.
  - On edge: B_DATA <= hold_a, ack_tgl <= req_s, B_UPDATE = 1 for exactly one cycle.
- A-side completion: ack_tgl passes through SYNC_STAGES CLKA flops to give ack_s. A_BUSY = req_tgl ^ ack_s.
- Latency:
  - Launch edge to B_DATA valid: SYNC_STAGES+1 CLKB edges (±1 for phase uncertainty).
  - A_BUSY duration: that latency plus SYNC_STAGES+1 CLKA edges.
- MODE 0 coalescing: changes of DATA_IN while busy are not queued. The value present on the first idle CLKA edge is sent. Intermediate values may be lost; the final value is always delivered.
- MODE 1 rule: the source holds A_VALID and DATA_IN until it sees A_READY on a CLKA edge. A_VALID while busy is ignored, not an error. Back-to-back pushes are allowed on the first cycle A_READY returns.
- A_VALID asserted while MODE 0: no effect.
- Equal value in MODE 1: the transfer still occurs and B_UPDATE still pulses.
- Reset mid-transfer: both sides return to reset values. The in-flight word is discarded and no B_UPDATE is generated after release.
- WIDTH = 1 is legal. There is no wrap or arithmetic beyond the 1-bit toggles.

Decomposition:
- Shared package adbg_sync_pkg:
  - localparams MODE_LEVEL = 0, MODE_PUSH = 1.
  - SYNC_STAGES_MIN = 2, SYNC_STAGES_MAX = 4.
  - An elaboration-time parameter check on SYNC_STAGES range and MODE value.
- One sub-module, adbg_sync_toggle: parametrised N-stage 1-bit synchroniser with async reset and a registered output edge pulse. It is instantiated twice, once for req into CLKB and once for ack into CLKA. Sync flops carry the team's standard CDC attribute.

Test Plan:
- Reset, then MODE 0 with DATA_IN held at RESET_VALUE = 0x0 for 50 CLKA cycles -> A_BUSY stays 0, B_UPDATE never pulses, B_DATA = 0x0.
- MODE 0, WIDTH = 8, CLKA 100 MHz, CLKB 37 MHz, DATA_IN 0x00 -> 0xA5 -> B_DATA = 0xA5 within SYNC_STAGES+2 CLKB edges; exactly one B_UPDATE pulse; A_BUSY drops afterward.
- MODE 0, DATA_IN steps 0x11, 0x22, 0x33 on consecutive CLKA cycles while busy -> B sees 0x11 then 0x33 only, two B_UPDATE pulses, never 0x22.
- MODE 1, 16 back-to-back pushes 0x0000..0x000F gated on A_READY, both clock ratios 3:1 and 1:3 -> B_UPDATE count = 16 and B_DATA sequence is in order with no loss or duplication.
- MODE 1, push 0x5 twice -> two B_UPDATE pulses, B_DATA = 0x5; A_VALID held while busy causes no extra transfer.
- RST asserted two CLKB cycles after a launch of 0xF -> B_DATA = RESET_VALUE, no B_UPDATE after release; A_READY = 1 on the first CLKA edge after release.
